// File: rtl/tl_pkg.sv
// Shared types and constants for the traffic light controller.
// Phase encoding, one-hot color constants and the count width live here.
package tl_pkg;

    localparam int COUNT_W = 7;

    localparam logic [2:0] COLOR_RED    = 3'b100;
    localparam logic [2:0] COLOR_YELLOW = 3'b010;
    localparam logic [2:0] COLOR_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        ST_RED    = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } tl_state_e;

    function automatic tl_state_e next_phase(input tl_state_e s);
        case (s)
            ST_RED:   next_phase = ST_GREEN;
            ST_GREEN: next_phase = ST_YELLOW;
            default:  next_phase = ST_RED;
        endcase
    endfunction

    function automatic logic [2:0] color_of(input tl_state_e s);
        case (s)
            ST_GREEN:  color_of = COLOR_GREEN;
            ST_YELLOW: color_of = COLOR_YELLOW;
            default:   color_of = COLOR_RED;
        endcase
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second prescaler: counts 0..CLK_FREQ-1 while iRUN is high and
// emits a single-cycle tick on the wrap back to zero.
module tl_tick_gen #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iRUN,
    output logic tick
);

    localparam int            PW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_FREQ - 1);

    logic [PW-1:0] r_presc;
    logic          w_wrap;

    assign w_wrap = iRUN && (r_presc == LAST);
    assign tick   = w_wrap;

    // Frozen (iRUN low) keeps the partial second so resume is seamless.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_presc <= '0;
        end else if (w_wrap) begin
            r_presc <= '0;
        end else if (iRUN) begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Red -> green -> yellow traffic light FSM with per-phase seconds countdown.
// Define TL_PED_REQ_EN to add the iPED_REQ input that shortens green.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int RED_TIME    = 30,
    parameter int GREEN_TIME  = 25,
    parameter int YELLOW_TIME = 5,
    parameter int PED_TIME    = 5
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iRUN,
`ifdef TL_PED_REQ_EN
    input  logic               iPED_REQ,
`endif
    output logic [2:0]         color,
    output logic [COUNT_W-1:0] count,
    output logic               enable,
    output logic               start
);

    localparam logic [COUNT_W-1:0] RED_LOAD    = COUNT_W'(RED_TIME);
    localparam logic [COUNT_W-1:0] GREEN_LOAD  = COUNT_W'(GREEN_TIME);
    localparam logic [COUNT_W-1:0] YELLOW_LOAD = COUNT_W'(YELLOW_TIME);
    localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);

    if (RED_TIME < 1 || RED_TIME > 99 || GREEN_TIME < 1 || GREEN_TIME > 99 ||
        YELLOW_TIME < 1 || YELLOW_TIME > 99 || PED_TIME < 1 || PED_TIME > 99 ||
        CLK_FREQ < 1) begin : g_bad_params
        $error("traffic_light_ctrl: phase times must be 1..99 and CLK_FREQ >= 1");
    end

    tl_state_e          r_state;
    logic [COUNT_W-1:0] r_count;
    logic [2:0]         r_color;
    logic               r_start;
    logic               r_enable;

    tl_state_e          w_state_nxt;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               w_advance;
    logic               w_tick;

`ifdef TL_PED_REQ_EN
    localparam logic [COUNT_W-1:0] PED_LOAD = COUNT_W'(PED_TIME);
    logic r_ped_flag;
    logic w_ped_nxt;
`endif

    tl_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick_gen (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iRUN   (iRUN),
        .tick   (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_advance   = 1'b0;
`ifdef TL_PED_REQ_EN
        w_ped_nxt   = r_ped_flag;
`endif
        if (w_tick) begin
            if (r_count > ONE) begin
                w_count_nxt = r_count - ONE;
            end else begin
                w_advance   = 1'b1;
                w_state_nxt = next_phase(r_state);
                case (w_state_nxt)
                    ST_GREEN:  w_count_nxt = GREEN_LOAD;
                    ST_YELLOW: w_count_nxt = YELLOW_LOAD;
                    default:   w_count_nxt = RED_LOAD;
                endcase
            end
        end
`ifdef TL_PED_REQ_EN
        // A pending request is only consumed in green; its load overrides a tick.
        if (r_ped_flag && (r_state == ST_GREEN)) begin
            w_ped_nxt = 1'b0;
            if (r_count > PED_LOAD) begin
                w_count_nxt = PED_LOAD;
            end
        end
        if (iPED_REQ) begin
            w_ped_nxt = 1'b1;
        end
`endif
    end

    // start is suppressed right after a pulse so it can never be two cycles wide.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state  <= ST_RED;
            r_count  <= RED_LOAD;
            r_color  <= COLOR_RED;
            r_start  <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_color  <= color_of(w_state_nxt);
            r_start  <= w_advance && !r_start;
            r_enable <= iRUN;
        end
    end

`ifdef TL_PED_REQ_EN
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_ped_flag <= 1'b0;
        end else begin
            r_ped_flag <= w_ped_nxt;
        end
    end
`endif

    assign color  = r_color;
    assign count  = r_count;
    assign enable = r_enable;
    assign start  = r_start;

endmodule
